// File: rtl/x_mem_arb_pkg.sv
// rtl/x_mem_arb_pkg.sv - shared types for the fetch/load-store memory arbiter
package x_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

endpackage

// File: rtl/x_mem_arb.sv
// rtl/x_mem_arb.sv - single-port memory arbiter between instruction fetch and load/store
module x_mem_arb
    import x_mem_arb_pkg::*;
#(
    parameter int P_LS_MAX = 4,
    parameter int P_AW     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    input  logic [P_AW-1:0] i_if_addr,
    output logic            o_if_accept,
    output logic [P_AW-1:0] o_if_data,
    input  logic            i_ls_valid,
    input  logic            i_ls_we,
    input  logic [P_AW-1:0] i_ls_addr,
    input  logic [P_AW-1:0] i_ls_wdata,
    output logic            o_ls_accept,
    output logic [P_AW-1:0] o_ls_rdata,
    output logic            o_mem_valid,
    output logic            o_mem_we,
    output logic [P_AW-1:0] o_mem_addr,
    output logic [P_AW-1:0] o_mem_wdata,
    input  logic            i_mem_accept,
    input  logic [P_AW-1:0] i_mem_rdata
);

    localparam int CW = $clog2(P_LS_MAX + 1);
    localparam logic [CW-1:0] LS_MAX = CW'(P_LS_MAX);

    state_t          state, state_nxt;
    logic [CW-1:0]   ls_cnt, ls_cnt_nxt;
    logic            grant;
    req_id_t         grant_id;
    logic            lat_we;
    logic [P_AW-1:0] lat_addr;
    logic [P_AW-1:0] lat_wdata;
    logic            busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ls_cnt <= '0;
        end else begin
            state <= state_nxt;
            ls_cnt <= ls_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ls_cnt_nxt = ls_cnt;
        grant = 1'b0;
        grant_id = REQ_IF;
        case (state)
            ST_IDLE: begin
                if (i_if_valid && i_ls_valid) begin
                    grant = 1'b1;
                    grant_id = (ls_cnt == LS_MAX) ? REQ_IF : REQ_LS;
                end else if (i_if_valid) begin
                    grant = 1'b1;
                    grant_id = REQ_IF;
                end else if (i_ls_valid) begin
                    grant = 1'b1;
                    grant_id = REQ_LS;
                end
                // The counter only tracks LS grants that made a waiting fetch wait longer.
                if (!i_if_valid || grant_id == REQ_IF) begin
                    ls_cnt_nxt = '0;
                end else if (ls_cnt != LS_MAX) begin
                    ls_cnt_nxt = ls_cnt + CW'(1);
                end
                if (grant) begin
                    state_nxt = (grant_id == REQ_IF) ? ST_BUSY_IF : ST_BUSY_LS;
                end
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (i_mem_accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Fetches are latched as reads with zero write data so the bus is clean.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_we <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            if (grant_id == REQ_IF) begin
                lat_we <= 1'b0;
                lat_addr <= i_if_addr;
                lat_wdata <= '0;
            end else begin
                lat_we <= i_ls_we;
                lat_addr <= i_ls_addr;
                lat_wdata <= i_ls_wdata;
            end
        end
    end

    assign busy        = (state == ST_BUSY_IF) || (state == ST_BUSY_LS);
    assign o_mem_valid = busy;
    assign o_mem_we    = busy && lat_we;
    assign o_mem_addr  = busy ? lat_addr : '0;
    assign o_mem_wdata = busy ? lat_wdata : '0;

    assign o_if_accept = (state == ST_BUSY_IF) && i_mem_accept;
    assign o_ls_accept = (state == ST_BUSY_LS) && i_mem_accept;
    assign o_if_data   = o_if_accept ? i_mem_rdata : '0;
    assign o_ls_rdata  = o_ls_accept ? i_mem_rdata : '0;

endmodule

// File: tb/tb_x_mem_arb.sv
// tb/tb_x_mem_arb.sv - directed scoreboard bench for x_mem_arb
module tb_x_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_accept;
    logic [31:0] if_data;
    logic        ls_valid;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_accept;
    logic [31:0] ls_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_accept;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    x_mem_arb dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_if_valid   (if_valid),
        .i_if_addr    (if_addr),
        .o_if_accept  (if_accept),
        .o_if_data    (if_data),
        .i_ls_valid   (ls_valid),
        .i_ls_we      (ls_we),
        .i_ls_addr    (ls_addr),
        .i_ls_wdata   (ls_wdata),
        .o_ls_accept  (ls_accept),
        .o_ls_rdata   (ls_rdata),
        .o_mem_valid  (mem_valid),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_accept (mem_accept),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
        chk({tag, "_bus"}, {mem_we, mem_addr, mem_wdata[30:0]}, 64'd0);
        chk({tag, "_accepts"}, {62'd0, if_accept, ls_accept}, 64'd0);
        chk({tag, "_data"}, {if_data, ls_rdata}, 64'd0);
    endtask

    task automatic chk_bus_against(input string tag, input req_t e);
        chk({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd1);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, {63'd0, e.we});
        chk({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, e.addr});
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, e.wdata});
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
    task automatic run_txn(input logic ls, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wait_cyc, input string tag);
        req_t e;
        e.ls = ls;
        e.we = ls ? we : 1'b0;
        e.addr = addr;
        e.wdata = ls ? wdata : 32'd0;
        if (ls) begin
            ls_valid = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_valid = 1'b1; if_addr = addr;
        end
        exp_q.push_back(e);
        #4;
        chk({tag, "_req_cycle_mem_valid"}, {63'd0, mem_valid}, 64'd0);
        next_cycle();
        // Requester side misbehaves mid-transaction; the latched request must stand.
        if (ls) begin
            ls_valid = 1'b0; ls_we = ~we; ls_addr = ~addr; ls_wdata = ~wdata;
        end else begin
            if_addr = ~addr;
        end
        e = exp_q.pop_front();
        for (int k = 0; k < wait_cyc; k++) begin
            #4;
            chk_bus_against({tag, "_wait"}, e);
            chk({tag, "_wait_accepts"}, {62'd0, if_accept, ls_accept}, 64'd0);
            next_cycle();
        end
        mem_accept = 1'b1;
        mem_rdata = rdata;
        #4;
        chk_bus_against({tag, "_acc"}, e);
        chk({tag, "_if_accept"}, {63'd0, if_accept}, {63'd0, ~ls});
        chk({tag, "_ls_accept"}, {63'd0, ls_accept}, {63'd0, ls});
        chk({tag, "_if_data"}, {32'd0, if_data}, ls ? 64'd0 : {32'd0, rdata});
        chk({tag, "_ls_rdata"}, {32'd0, ls_rdata}, ls ? {32'd0, rdata} : 64'd0);
        next_cycle();
        mem_accept = 1'b0; mem_rdata = 32'd0;
        if_valid = 1'b0; ls_valid = 1'b0;
        #4;
        chk_idle_outputs({tag, "_after"});
        next_cycle();
    endtask

    initial begin
        int   grants;
        int   budget;
        req_t e;

        rst = 1'b1;
        if_valid = 1'b0; if_addr = 32'd0;
        ls_valid = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
        mem_accept = 1'b0; mem_rdata = 32'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #4;
        chk_idle_outputs("reset");
        next_cycle();

        // Stray memory accept while idle must be ignored.
        mem_accept = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        #4;
        chk_idle_outputs("idle_stray_accept");
        next_cycle();
        mem_accept = 1'b0; mem_rdata = 32'd0;
        #4;
        chk_idle_outputs("idle_stray_after");
        next_cycle();

        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'h0050_0093, 2, "fetch");
        run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0, "store");
        run_txn(1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'h0000_CAFE, 1, "load");

        // Both requesters always asserting, memory always accepting.
        if_valid = 1'b1; if_addr = 32'h0000_0040;
        ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0080; ls_wdata = 32'd0;
        mem_accept = 1'b1; mem_rdata = 32'h1111_2222;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back('{1'b1, 1'b0, 32'h0000_0080, 32'd0});
            exp_q.push_back('{1'b0, 1'b0, 32'h0000_0040, 32'd0});
        end
        grants = 0;
        budget = 0;
        while (grants < 10 && budget < 60) begin
            #4;
            if (mem_valid) begin
                e = exp_q.pop_front();
                chk($sformatf("order%0d_kind", grants), {62'd0, if_accept, ls_accept},
                    {62'd0, ~e.ls, e.ls});
                chk($sformatf("order%0d_addr", grants), {32'd0, mem_addr}, {32'd0, e.addr});
                grants++;
            end
            budget++;
            next_cycle();
        end
        chk("order_grant_count", 64'(grants), 64'd10);
        chk("order_queue_empty", 64'(exp_q.size()), 64'd0);
        if_valid = 1'b0; ls_valid = 1'b0;
        #4;
        chk("order_idle_mem_valid", {63'd0, mem_valid}, 64'd0);
        next_cycle();
        mem_accept = 1'b0; mem_rdata = 32'd0;
        next_cycle();

        // Reset while a load/store is outstanding.
        ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0300; ls_wdata = 32'h0BAD_F00D;
        next_cycle();
        #4;
        chk_bus_against("rst_busy", '{1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_F00D});
        next_cycle();
        rst = 1'b1;
        ls_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        mem_accept = 1'b1; mem_rdata = 32'h7777_7777;
        #4;
        chk_idle_outputs("rst_after");
        next_cycle();
        mem_accept = 1'b0; mem_rdata = 32'd0;
        next_cycle();

        run_txn(1'b0, 1'b0, 32'h0000_0400, 32'd0, 32'h1234_5678, 1, "post_rst_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
